// File: rtl/decode_pkg.sv
// Shared constants and types for the RV32I decode stage: opcodes,
// one-hot class bit positions and the decoded-field bundle.
package decode_pkg;

    localparam int unsigned CLASS_W = 12;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int unsigned CLS_ALU     = 0;
    localparam int unsigned CLS_ALU_I   = 1;
    localparam int unsigned CLS_LOAD    = 2;
    localparam int unsigned CLS_STORE   = 3;
    localparam int unsigned CLS_BRANCH  = 4;
    localparam int unsigned CLS_LUI     = 5;
    localparam int unsigned CLS_AUIPC   = 6;
    localparam int unsigned CLS_JAL     = 7;
    localparam int unsigned CLS_JALR    = 8;
    localparam int unsigned CLS_FENCE   = 9;
    localparam int unsigned CLS_SYSTEM  = 10;
    localparam int unsigned CLS_ILLEGAL = 11;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    // Immediate kept at 32 bits; the stage sign-extends to XLEN on output.
    typedef struct packed {
        logic [CLASS_W-1:0] cls;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic               funct7b5;
        logic [31:0]        imm;
    } dec_t;

endpackage

// File: rtl/decode_stage_instr_decode.sv
// Purely combinational RV32I field decode: op class, register fields
// (zeroed when the class does not use them) and 32-bit immediate.
module instr_decode
    import decode_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [CLASS_W-1:0] w_cls;
    imm_sel_e           w_sel;
    logic               w_use_rd;
    logic               w_use_rs1;
    logic               w_use_rs2;
    logic [31:0]        w_imm;

    // Opcode to class, immediate format and register-field usage.
    always_comb begin
        w_cls     = '0;
        w_sel     = IMM_NONE;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (i_instr[6:0])
            OP_ALU: begin
                w_cls[CLS_ALU] = 1'b1;
                w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            OP_ALU_I: begin
                w_cls[CLS_ALU_I] = 1'b1; w_sel = IMM_I;
                w_use_rd = 1'b1; w_use_rs1 = 1'b1;
            end
            OP_LOAD: begin
                w_cls[CLS_LOAD] = 1'b1; w_sel = IMM_I;
                w_use_rd = 1'b1; w_use_rs1 = 1'b1;
            end
            OP_STORE: begin
                w_cls[CLS_STORE] = 1'b1; w_sel = IMM_S;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                w_cls[CLS_BRANCH] = 1'b1; w_sel = IMM_B;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            OP_LUI: begin
                w_cls[CLS_LUI] = 1'b1; w_sel = IMM_U;
                w_use_rd = 1'b1;
            end
            OP_AUIPC: begin
                w_cls[CLS_AUIPC] = 1'b1; w_sel = IMM_U;
                w_use_rd = 1'b1;
            end
            OP_JAL: begin
                w_cls[CLS_JAL] = 1'b1; w_sel = IMM_J;
                w_use_rd = 1'b1;
            end
            OP_JALR: begin
                w_cls[CLS_JALR] = 1'b1; w_sel = IMM_I;
                w_use_rd = 1'b1; w_use_rs1 = 1'b1;
            end
            OP_FENCE: begin
                w_cls[CLS_FENCE] = 1'b1;
            end
            // CSR forms read rs1 and write rd.
            OP_SYSTEM: begin
                w_cls[CLS_SYSTEM] = 1'b1;
                w_use_rd = 1'b1; w_use_rs1 = 1'b1;
            end
            default: begin
                w_cls[CLS_ILLEGAL] = 1'b1;
            end
        endcase
    end

    // Immediate assembly, sign-extended from instr[31] to 32 bits.
    always_comb begin
        w_imm = '0;
        case (w_sel)
            IMM_I:   w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm = {i_instr[31:12], 12'b0};
            IMM_J:   w_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // Pack the decoded bundle.
    always_comb begin
        o_dec          = '0;
        o_dec.cls      = w_cls;
        o_dec.rd       = w_use_rd  ? i_instr[11:7]  : 5'd0;
        o_dec.rs1      = w_use_rs1 ? i_instr[19:15] : 5'd0;
        o_dec.rs2      = w_use_rs2 ? i_instr[24:20] : 5'd0;
        o_dec.funct3   = i_instr[14:12];
        o_dec.funct7b5 = i_instr[30];
        o_dec.imm      = w_imm;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: valid/ready handshake on both sides, one
// output register plus an optional one-entry skid buffer so that
// in_ready is a registered signal when SKID_EN=1.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [2:0]         out_funct3,
    output logic               out_funct7b5,
    output logic [XLEN-1:0]    out_imm,
    output logic [XLEN-1:0]    out_pc
);

    logic            r_out_valid;
    dec_t            r_out;
    logic [XLEN-1:0] r_out_pc;
    logic            r_skid_valid;
    dec_t            r_skid;
    logic [XLEN-1:0] r_skid_pc;

    dec_t            w_dec;
    logic            w_accept;
    logic            w_out_free;

    instr_decode u_instr_decode (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    assign w_out_free = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

    // Ready: blocked by reset/flush; otherwise skid-empty (registered) or
    // pass-through output-slot availability when no skid is built.
    always_comb begin
        in_ready = 1'b0;
        if (rst || flush) begin
            in_ready = 1'b0;
        end else if (SKID_EN) begin
            in_ready = !r_skid_valid;
        end else begin
            in_ready = w_out_free;
        end
    end

    // Output/skid entry update. A draining skid always refills the output
    // first; in_ready is low whenever the skid holds data, so no new entry
    // can race it and acceptance order is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_out_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_pc    <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out        <= r_skid;
                r_out_pc     <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out       <= w_dec;
                r_out_pc    <= in_pc;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept && SKID_EN) begin
            r_skid_valid <= 1'b1;
            r_skid       <= w_dec;
            r_skid_pc    <= in_pc;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_class    = r_out.cls;
    assign out_rd       = r_out.rd;
    assign out_rs1      = r_out.rs1;
    assign out_rs2      = r_out.rs2;
    assign out_funct3   = r_out.funct3;
    assign out_funct7b5 = r_out.funct7b5;
    assign out_imm      = XLEN'($signed(r_out.imm));
    assign out_pc       = r_out_pc;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width for pc and imm; legal values 32 or 64.
REQ-002 Parameter SKID_EN, default 1; 1 adds a one-entry skid buffer so in_ready does not depend combinationally on out_ready.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discards all held entries.
REQ-006 in_valid  input  1  instruction offered.
REQ-007 in_ready  output  1  stage accepts this cycle.
REQ-008 in_instr  input  32  raw RV32I instruction word.
REQ-009 in_pc  input  XLEN  instruction address.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  consumer accepts.
REQ-012 out_class  output  12  one-hot op class: ALU, ALU_I, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, FENCE, SYSTEM, ILLEGAL.
REQ-013 out_rd, out_rs1, out_rs2  output  5 each  register fields; forced to 0 when unused by the class.
REQ-014 out_funct3  output  3  instr[14:12]; out_funct7b5  output  1  instr[30].
REQ-015 out_imm  output  XLEN  sign-extended immediate.
REQ-016 out_pc  output  XLEN  pc of the decoded instruction.

Function
REQ-017 Transfer occurs on a rising edge with valid && ready on the respective side.
REQ-018 Latency: an instruction accepted in cycle N is presented on out_* in cycle N+1 when the stage was empty.
REQ-019 Class decode on opcode instr[6:0]: 0110011 ALU, 0010011 ALU_I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 0001111 FENCE, 1110011 SYSTEM; any other value, including instr[1:0] != 11, is ILLEGAL.
REQ-020 out_class is exactly one-hot whenever out_valid is 1.
REQ-021 Immediates: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); U = sext({instr[31:12],12'b0}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}). Sign-extension is to XLEN from bit 31.
REQ-022 Immediate selection: ALU_I, LOAD and JALR use I; STORE uses S; BRANCH uses B; LUI and AUIPC use U; JAL uses J. ALU, FENCE, SYSTEM and ILLEGAL drive imm 0.
REQ-023 Holding: out_* stays stable while out_valid && !out_ready.
REQ-024 SKID_EN=0: in_ready = !out_valid || out_ready.
REQ-025 SKID_EN=1: in_ready = skid buffer empty (registered). An input accepted while the output is stalled goes to the skid buffer. The skid buffer moves to the output on the next out_ready.
REQ-026 Ordering: outputs leave strictly in acceptance order; no drop or duplicate occurs except on flush.
REQ-027 Flush has priority over every transfer. In the flush cycle, no input is accepted (in_ready=0), and the output and skid entries are invalidated on that edge.
REQ-028 Simultaneous out_ready and in_valid on a full output with an empty skid buffer: the output is replaced by the new entry in the same edge, giving full throughput.

Reset
REQ-029 While rst is high: out_valid=0, skid buffer empty, in_ready=0. All out_* data fields are 0.
REQ-030 in_ready rises in the first cycle after rst deasserts.
REQ-031 Reset asserted mid-stall discards all entries; no entry is emitted after reset.

Structure
REQ-032 Package decode_pkg holds the opcode constants, the class bit-index constants and the class width 12.
REQ-033 The combinational field/immediate decode lives in sub-module instr_decode, instantiated once. Its input comes from the accepted in_instr, and its output is registered into the output or skid entry.

Verification
REQ-034 Send 0x00500093 (addi x1,x0,5). Required: after 1 cycle, class=ALU_I, rd=1, rs1=0, imm=5.
REQ-035 Send 0xFE000EE3 (beq x0,x0,-4). Required: class=BRANCH, imm=0xFFFFFFFC; with XLEN=64, imm=0xFFFFFFFFFFFFFFFC.
REQ-036 Send 0x00000000 and 0x0000007F. Required: class=ILLEGAL and imm=0 for both.
REQ-037 Hold out_ready=0 for 3 cycles while sending 3 instructions with SKID_EN=1. Required: 2 are accepted, in_ready=0 afterwards; releasing the stall emits them in order, one per cycle.
REQ-038 Assert flush while both entries are full. Required: out_valid=0 next cycle, and the next accepted instruction appears after 1 cycle.
REQ-039 Apply back-to-back valid with out_ready=1 for 100 random opcodes. Required: 100 outputs in order, one per cycle, each class one-hot.
